// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback formatting for the RV32I core.
// Aligns and extends load data, drives the regfile write port and keeps instret.
module writeback_stage #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [6:0]           opcode_in,
    input  logic [2:0]           funct3_in,
    input  logic [4:0]           rd_in,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [XLEN-1:0]      alu_res_in,
    input  logic [XLEN-1:0]      mem_res_in,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 wb_valid,
    output logic                 misaligned,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpReg    = 7'b0110011,
        OpImm    = 7'b0010011,
        OpLui    = 7'b0110111,
        OpAuipc  = 7'b0010111,
        OpStore  = 7'b0100011,
        OpBranch = 7'b1100011
    } opcode_e;

    logic                 valid_q,  valid_d;
    logic [6:0]           opcode_q, opcode_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [4:0]           rd_q,     rd_d;
    logic [XLEN-1:0]      pc_q,     pc_d;
    logic [XLEN-1:0]      alu_q,    alu_d;
    logic [XLEN-1:0]      mem_q,    mem_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    logic [1:0]      off;
    logic [XLEN-1:0] shifted;
    logic [7:0]      byteSel;
    logic [15:0]     halfSel;
    logic [XLEN-1:0] result;
    logic            writes;
    logic            isIllegal;
    logic            isHalf;
    logic            isWord;

    // Stall outranks flush; a bubble only clears valid, the payload is don't-care.
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        alu_d    = alu_q;
        mem_d    = mem_q;
        if (!stall) begin
            if (flush || !valid_in) begin
                valid_d = 1'b0;
            end else begin
                valid_d  = 1'b1;
                opcode_d = opcode_in;
                funct3_d = funct3_in;
                rd_d     = rd_in;
                pc_d     = pc_in;
                alu_d    = alu_res_in;
                mem_d    = mem_res_in;
            end
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (valid_q && !stall && !illegal && !misaligned) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            alu_q     <= '0;
            mem_q     <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            instret_q <= instret_d;
        end
    end

    // Memory returns the whole aligned word; the low address bits pick the lane.
    assign off     = alu_q[1:0];
    assign shifted = mem_q >> {off, 3'b000};
    assign byteSel = shifted[7:0];
    assign halfSel = off[1] ? mem_q[31:16] : mem_q[15:0];

    always_comb begin
        writes    = 1'b0;
        isIllegal = 1'b0;
        isHalf    = 1'b0;
        isWord    = 1'b0;
        result    = '0;
        case (opcode_q)
            OpLoad: begin
                writes = 1'b1;
                case (funct3_q)
                    3'b000: result = {{(XLEN-8){byteSel[7]}}, byteSel};
                    3'b100: result = {{(XLEN-8){1'b0}}, byteSel};
                    3'b001: begin
                        isHalf = 1'b1;
                        result = {{(XLEN-16){halfSel[15]}}, halfSel};
                    end
                    3'b101: begin
                        isHalf = 1'b1;
                        result = {{(XLEN-16){1'b0}}, halfSel};
                    end
                    3'b010: begin
                        isWord = 1'b1;
                        result = mem_q;
                    end
                    default: begin
                        writes    = 1'b0;
                        isIllegal = 1'b1;
                    end
                endcase
            end
            OpJal, OpJalr: begin
                writes = 1'b1;
                result = pc_q + XLEN'(4);
            end
            OpReg, OpImm, OpLui, OpAuipc: begin
                writes = 1'b1;
                result = alu_q;
            end
            OpStore, OpBranch: writes = 1'b0;
            default: isIllegal = 1'b1;
        endcase
    end

    assign misaligned = valid_q & ((isHalf & off[0]) | (isWord & (off != 2'b00)));
    assign illegal    = valid_q & isIllegal;
    assign wb_en      = valid_q & writes & (rd_q != 5'd0) & ~misaligned & ~illegal;
    assign wb_data    = wb_en ? result : '0;
    assign wb_rd      = rd_q;
    assign wb_valid   = valid_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: issued instructions queue their expected
// writeback, and a monitor pops and compares each freshly captured WB entry.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [6:0]  opcode_in = '0;
    logic [2:0]  funct3_in = '0;
    logic [4:0]  rd_in = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] alu_res_in = '0;
    logic [31:0] mem_res_in = '0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        misaligned;
    logic        illegal;
    logic [63:0] instret;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic capturedLast = 1'b0;

    writeback_stage #(.XLEN(32), .CNT_WIDTH(64)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
        .opcode_in(opcode_in), .funct3_in(funct3_in), .rd_in(rd_in), .pc_in(pc_in),
        .alu_res_in(alu_res_in), .mem_res_in(mem_res_in), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_valid(wb_valid), .misaligned(misaligned), .illegal(illegal),
        .instret(instret)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Only entries captured on an unstalled edge are new; held entries are checked directly.
    always @(posedge clock) capturedLast <= !reset && !stall;

    always @(negedge clock) begin
        if (!reset && capturedLast && wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_wb: got wb_valid=1, expected no instruction");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("wb_en", 64'(wb_en), 64'(e.en));
                checkOutput("wb_data", 64'(wb_data), 64'(e.data));
                checkOutput("misaligned", 64'(misaligned), 64'(e.mis));
                checkOutput("illegal", 64'(illegal), 64'(e.ill));
                if (e.en) checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic s, input logic f,
                                 input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                                 input logic eEn, input logic [31:0] eData,
                                 input logic eMis, input logic eIll);
        exp_t e;
        @(negedge clock);
        valid_in   = v;
        stall      = s;
        flush      = f;
        opcode_in  = op;
        funct3_in  = f3;
        rd_in      = rd;
        pc_in      = pc;
        alu_res_in = alu;
        mem_res_in = mem;
        if (v && !s && !f) begin
            e.en = eEn; e.rd = rd; e.data = eData; e.mis = eMis; e.ill = eIll;
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem,
                         input logic eEn, input logic [31:0] eData, input logic eMis, input logic eIll);
        applyStimulus(1'b1, 1'b0, 1'b0, op, f3, rd, pc, alu, mem, eEn, eData, eMis, eIll);
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic checkFrozen();
        checkOutput("stall_wb_valid", 64'(wb_valid), 64'd1);
        checkOutput("stall_wb_en", 64'(wb_en), 64'd1);
        checkOutput("stall_wb_rd", 64'(wb_rd), 64'd13);
        checkOutput("stall_wb_data", 64'(wb_data), 64'hDEADBEEF);
        checkOutput("stall_instret", instret, 64'd11);
    endtask

    initial begin
        #1;
        checkOutput("reset_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("reset_wb_en", 64'(wb_en), 64'd0);
        checkOutput("reset_wb_data", 64'(wb_data), 64'd0);
        checkOutput("reset_instret", instret, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Load formatting, link addresses and ALU writes.
        issue(7'b0000011, 3'b000, 5'd5,  32'h0,        32'h00001003, 32'h80FF1234, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
        issue(7'b0000011, 3'b101, 5'd6,  32'h0,        32'h00002002, 32'hBEEF0000, 1'b1, 32'h0000BEEF, 1'b0, 1'b0);
        issue(7'b0000011, 3'b010, 5'd7,  32'h0,        32'h00002001, 32'h12345678, 1'b0, 32'h00000000, 1'b1, 1'b0);
        issue(7'b1101111, 3'b000, 5'd1,  32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0);
        issue(7'b0110011, 3'b000, 5'd0,  32'h0,        32'h00001234, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0);
        issue(7'b0000011, 3'b001, 5'd8,  32'h0,        32'h00000012, 32'h80010000, 1'b1, 32'hFFFF8001, 1'b0, 1'b0);
        issue(7'b0000011, 3'b100, 5'd9,  32'h0,        32'h00000001, 32'h0000AB00, 1'b1, 32'h000000AB, 1'b0, 1'b0);
        issue(7'b1100111, 3'b000, 5'd10, 32'h00000100, 32'h0,        32'h0,        1'b1, 32'h00000104, 1'b0, 1'b0);
        issue(7'b0110111, 3'b000, 5'd11, 32'h0,        32'hABCDE000, 32'h0,        1'b1, 32'hABCDE000, 1'b0, 1'b0);
        issue(7'b0000011, 3'b011, 5'd3,  32'h0,        32'h00000000, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b1);
        bubble();
        bubble();
        checkOutput("instret_after_loads", instret, 64'd8);

        issue(7'b0100011, 3'b010, 5'd4,  32'h0, 32'h00000040, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(7'b1100011, 3'b000, 5'd2,  32'h0, 32'h00000080, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(7'b0010011, 3'b000, 5'd12, 32'h0, 32'h00000005, 32'h0, 1'b1, 32'h00000005, 1'b0, 1'b0);
        bubble();
        bubble();
        checkOutput("instret_after_store_branch", instret, 64'd11);

        issue(7'b1111111, 3'b000, 5'd6, 32'h0, 32'h00000000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        bubble();
        bubble();
        checkOutput("instret_after_illegal", instret, 64'd11);

        // Stall with flush holds the WB entry and the counter.
        issue(7'b0110011, 3'b000, 5'd13, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 7'b0110011, 3'd0, 5'd20, 32'h0, 32'h1111, 32'h0, 1'b1, 32'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 7'b0110011, 3'd0, 5'd20, 32'h0, 32'h1111, 32'h0, 1'b1, 32'h1111, 1'b0, 1'b0);
        checkFrozen();
        applyStimulus(1'b1, 1'b1, 1'b1, 7'b0110011, 3'd0, 5'd20, 32'h0, 32'h1111, 32'h0, 1'b1, 32'h1111, 1'b0, 1'b0);
        checkFrozen();
        applyStimulus(1'b1, 1'b0, 1'b1, 7'b0110011, 3'd0, 5'd21, 32'h0, 32'h2222, 32'h0, 1'b1, 32'h2222, 1'b0, 1'b0);
        checkFrozen();
        bubble();
        checkOutput("flush_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("flush_wb_en", 64'(wb_en), 64'd0);
        checkOutput("flush_instret", instret, 64'd12);

        // Asynchronous reset while a write is being presented.
        issue(7'b0010011, 3'b000, 5'd14, 32'h0, 32'h00000077, 32'h0, 1'b1, 32'h00000077, 1'b0, 1'b0);
        bubble();
        checkOutput("pre_reset_wb_en", 64'(wb_en), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_wb_en", 64'(wb_en), 64'd0);
        checkOutput("midreset_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("midreset_wb_data", 64'(wb_data), 64'd0);
        checkOutput("midreset_instret", instret, 64'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;

        issue(7'b0010111, 3'b000, 5'd15, 32'h0, 32'h00001000, 32'h0, 1'b1, 32'h00001000, 1'b0, 1'b0);
        bubble();
        bubble();
        checkOutput("instret_after_reset", instret, 64'd1);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
